df_control_mc: RTL and testbench
================================

Name: df_control_mc

Overview:
- Multi-channel data-flow controller; parametrised successor to the single-FIFO df control.
- Sits between one upstream push source, NUM_CH downstream FIFOs and one shared egress.
- Steers each push to its destination FIFO and drains the non-empty FIFOs round-robin.
- Generates per-channel pause with hysteresis and a sticky Error.

Parameters:
- NUM_CH, 4: number of FIFO channels, 2..8.
- CH_W, 2: width of the channel index; must satisfy 2**CH_W >= NUM_CH.
- ERR_CNT_W, 8: width of the optional error counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push_0  in  1  upstream push request, one word per cycle.
- push_dest  in  CH_W  destination channel of push_0.
- egress_ready  in  1  shared egress can accept one word this cycle.
- fifo_empty  in  NUM_CH  per-channel empty flag.
- Fifo_full  in  NUM_CH  per-channel full flag.
- almost_full  in  NUM_CH  per-channel almost-full flag.
- almost_empty  in  NUM_CH  per-channel almost-empty flag.
- fifo_error  in  NUM_CH  per-channel FIFO error flag.
- write  out  NUM_CH  one-hot FIFO write strobe.
- read  out  NUM_CH  one-hot FIFO read strobe.
- fifo_pause  out  NUM_CH  per-channel back-pressure to upstream.
- pop_valid  out  1  a read is issued this cycle.
- pop_ch  out  CH_W  index of the channel being read.
- state  out  2  FSM state: IDLE=0, ACTIVE=1, ERROR=2.
- Error  out  1  sticky error flag.
- err_count  out  ERR_CNT_W  saturating error-event count.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE and the round-robin pointer rr_ptr is 0.
- The reset value is applied on the first clk edge with reset high. Reset mid-operation aborts any in-flight grant with no partial strobes.

- Write path (combinational):
  - write[push_dest] = push_0 && !Fifo_full[push_dest] && state!=ERROR.
  - All other bits of write are 0.
  - push_dest >= NUM_CH: no write, and the push counts as an error event.
- Overflow: push_0 with Fifo_full[push_dest]=1 drops the word and is an error event.
- Simultaneous write and read on the same channel is allowed; the FIFO handles it.

- Read path:
  - Grant goes to the first channel i with fifo_empty[i]==0, searching from rr_ptr upward and wrapping modulo NUM_CH.
  - A grant is issued only when egress_ready==1 and state==ACTIVE.
  - read[i], pop_valid and pop_ch=i are combinational in the grant cycle.
  - After a grant, rr_ptr <= (i+1) mod NUM_CH on the next edge. With no grant, rr_ptr holds.
  - Latency is 0 cycles from egress_ready to read. At most one read is issued per cycle.

- Pause (registered, per channel, one-cycle latency):
  - Set when almost_full[i]==1.
  - Cleared when almost_empty[i]==1.
  - Holds otherwise.
  - If both flags are high, set wins.
  - Fifo_full[i] also forces the set.

- Error events: any fifo_error bit high, overflow, or an illegal push_dest. Several events in one cycle count as one.
- Error is set on the edge after the first event and stays set until reset.

- FSM:
  - IDLE -> ACTIVE when any fifo_empty bit is 0.
  - ACTIVE -> IDLE when all FIFOs are empty and no write is occurring this cycle.
  - Any state -> ERROR on an error event. ERROR has priority over the other transitions.
  - ERROR exits only on reset.
  - In ERROR, write, read and pop_valid are forced to 0 and every fifo_pause bit is forced to 1.

Optional Feature:
- Macro: DFCONTROL_ERRCNT_EN.
- Defined: err_count increments by 1 per cycle with an error event and saturates at all-ones. It keeps counting while in ERROR. Reset clears it to 0.
- Undefined: err_count is tied to 0 and no counter flops are built. All other behaviour is unchanged.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, ACTIVE, ERROR);
  - default NUM_CH and CH_W;
  - the width-check constant.
- One natural sub-module, rr_arbiter_nch:
  - inputs: NUM_CH request vector and rr_ptr;
  - outputs: one-hot grant plus grant index.
- The pointer register stays in df_control_mc.

Test Plan:
1. Reset with all FIFOs empty, then push_0=1 with push_dest=2 -> write=0100, state IDLE->ACTIVE after 1 cycle, Error=0.
2. fifo_empty=0000 (NUM_CH=4) with egress_ready=1 for 5 cycles -> pop_ch sequence 0,1,2,3,0 with one-hot read each cycle.
3. almost_full[1]=1 for 1 cycle, then both flags low for 3 cycles, then almost_empty[1]=1 -> fifo_pause[1] rises 1 cycle later, holds, and falls 1 cycle after almost_empty.
4. push_0=1 with push_dest=3 and Fifo_full[3]=1 -> write=0000, Error=1 and state=ERROR next cycle, all fifo_pause bits=1, read stays 0 with egress_ready=1. With the macro defined, err_count=1.
5. With the macro defined, hold fifo_error[0]=1 for 300 cycles -> err_count saturates at 255. Then reset -> all outputs 0 and state IDLE.
6. Assert reset during a grant cycle (read=0010) -> next cycle read=0, rr_ptr=0, and the first grant after reset is channel 0.

Source files
------------

// File: rtl/df_control_mc_pkg.sv
//==============================================================================
// Module      : df_control_mc_pkg
// Description : Shared types and constants for the multi-channel data-flow
//               controller: FSM state encodings, default channel geometry
//               and the channel-index width check.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package df_control_mc_pkg;

  // FSM state encodings, visible on the state output port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  // Default channel geometry.
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = 2;

  // Legal channel-count range.
  localparam int MIN_NUM_CH = 2;
  localparam int MAX_NUM_CH = 8;

  // True when the channel count is legal and the index width can address it.
  function automatic bit cfg_ok(input int num_ch, input int ch_w);
    return (num_ch >= MIN_NUM_CH) && (num_ch <= MAX_NUM_CH) &&
           ((1 << ch_w) >= num_ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/df_control_mc_rr_arbiter_nch.sv
//==============================================================================
// Module      : rr_arbiter_nch
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or above ptr, wrapping modulo NUM_CH. Produces a
//               one-hot grant, the granted index and a valid flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter_nch #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_valid
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest request to ptr wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (req[idx]) begin
        gnt       = '0;
        gnt[idx]  = 1'b1;
        gnt_idx   = CH_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/df_control_mc.sv
//==============================================================================
// Module      : df_control_mc
// Description : Multi-channel data-flow controller. Steers upstream pushes to
//               one of NUM_CH FIFOs, drains non-empty FIFOs round-robin into a
//               shared egress, drives per-channel pause with hysteresis and
//               raises a sticky Error on overflow, illegal destination or any
//               FIFO error.
//               Optional feature macro: DFCONTROL_ERRCNT_EN (saturating
//               error-event counter on err_count; tied to 0 when undefined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module df_control_mc
  import df_control_mc_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_W      = DEF_CH_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_0,
  input  logic [CH_W-1:0]      push_dest,
  input  logic                 egress_ready,
  input  logic [NUM_CH-1:0]    fifo_empty,
  input  logic [NUM_CH-1:0]    Fifo_full,
  input  logic [NUM_CH-1:0]    almost_full,
  input  logic [NUM_CH-1:0]    almost_empty,
  input  logic [NUM_CH-1:0]    fifo_error,
  output logic [NUM_CH-1:0]    write,
  output logic [NUM_CH-1:0]    read,
  output logic [NUM_CH-1:0]    fifo_pause,
  output logic                 pop_valid,
  output logic [CH_W-1:0]      pop_ch,
  output logic [1:0]           state,
  output logic                 Error,
  output logic [ERR_CNT_W-1:0] err_count
);

  if (!cfg_ok(NUM_CH, CH_W)) begin : g_bad_cfg
    $error("df_control_mc: illegal NUM_CH/CH_W combination");
  end

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr;
  logic [NUM_CH-1:0]   pause_q;
  logic                error_q;

  logic [NUM_CH-1:0]   dest_hit;
  logic                dest_full;
  logic                dest_illegal;
  logic                overflow;
  logic                err_event;

  logic [NUM_CH-1:0]   arb_gnt;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_valid;
  logic                grant;

  // Decode push_dest; an index beyond the last channel decodes to no bit.
  always_comb begin
    dest_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_dest == CH_W'(i)) dest_hit[i] = 1'b1;
    end
  end

  assign dest_full    = |(dest_hit & Fifo_full);
  assign dest_illegal = push_0 && !(|dest_hit);
  assign overflow     = push_0 && dest_full;
  assign err_event    = (|fifo_error) || overflow || dest_illegal;

  assign write = (push_0 && !dest_full && (state_q != ST_ERROR)) ? dest_hit : '0;

  rr_arbiter_nch #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (~fifo_empty),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign grant     = arb_valid && egress_ready && (state_q == ST_ACTIVE);
  assign read      = grant ? arb_gnt : '0;
  assign pop_valid = grant;
  assign pop_ch    = grant ? arb_idx : '0;

  // Next-state logic; an error event overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!(&fifo_empty)) state_d = ST_ACTIVE;
      ST_ACTIVE: if ((&fifo_empty) && !(|write)) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase
    if (err_event) state_d = ST_ERROR;
  end

  // State register and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_event) error_q <= 1'b1;
    end
  end

  // Round-robin pointer advances past the granted channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + CH_W'(1);
    end
  end

  // Pause hysteresis: almost_full or full sets, almost_empty clears, set wins.
  always_ff @(posedge clk) begin
    if (reset) pause_q <= '0;
    else       pause_q <= (almost_full | Fifo_full) | (pause_q & ~almost_empty);
  end

  assign fifo_pause = (state_q == ST_ERROR) ? '1 : pause_q;
  assign state      = state_q;
  assign Error      = error_q;

`ifdef DFCONTROL_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // One count per cycle with any error event, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                           err_cnt_q <= '0;
    else if (err_event && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_df_control_mc.sv
//==============================================================================
// Module      : tb_df_control_mc
// Description : Directed self-checking bench for df_control_mc (NUM_CH=4).
//               Expected err_count follows DFCONTROL_ERRCNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_df_control_mc;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int ERR_CNT_W = 8;

`ifdef DFCONTROL_ERRCNT_EN
  localparam int EXP_CNT_ONE = 1;
  localparam int EXP_CNT_SAT = 255;
`else
  localparam int EXP_CNT_ONE = 0;
  localparam int EXP_CNT_SAT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 push_0;
  logic [CH_W-1:0]      push_dest;
  logic                 egress_ready;
  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH-1:0]    Fifo_full;
  logic [NUM_CH-1:0]    almost_full;
  logic [NUM_CH-1:0]    almost_empty;
  logic [NUM_CH-1:0]    fifo_error;
  logic [NUM_CH-1:0]    write;
  logic [NUM_CH-1:0]    read;
  logic [NUM_CH-1:0]    fifo_pause;
  logic                 pop_valid;
  logic [CH_W-1:0]      pop_ch;
  logic [1:0]           state;
  logic                 Error;
  logic [ERR_CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  df_control_mc #(
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push_0       (push_0),
    .push_dest    (push_dest),
    .egress_ready (egress_ready),
    .fifo_empty   (fifo_empty),
    .Fifo_full    (Fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error),
    .write        (write),
    .read         (read),
    .fifo_pause   (fifo_pause),
    .pop_valid    (pop_valid),
    .pop_ch       (pop_ch),
    .state        (state),
    .Error        (Error),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_write"},  32'(write),      32'h0);
    check_value({tag, "_read"},   32'(read),       32'h0);
    check_value({tag, "_pause"},  32'(fifo_pause), 32'h0);
    check_value({tag, "_popv"},   32'(pop_valid),  32'h0);
    check_value({tag, "_popch"},  32'(pop_ch),     32'h0);
    check_value({tag, "_state"},  32'(state),      32'h0);
    check_value({tag, "_error"},  32'(Error),      32'h0);
    check_value({tag, "_errcnt"}, 32'(err_count),  32'h0);
  endtask

  initial begin
    int exp_ch [5] = '{0, 1, 2, 3, 0};

    reset        = 1'b1;
    push_0       = 1'b0;
    push_dest    = '0;
    egress_ready = 1'b0;
    fifo_empty   = 4'b1111;
    Fifo_full    = '0;
    almost_full  = '0;
    almost_empty = '0;
    fifo_error   = '0;

    // Reset state after the first edge with reset high.
    tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // 1: push to channel 2 while all FIFOs are empty.
    push_0    = 1'b1;
    push_dest = 2'd2;
    #1;
    check_value("t1_write", 32'(write), 32'b0100);
    check_value("t1_idle",  32'(state), 32'd0);
    tick();
    push_0     = 1'b0;
    fifo_empty = 4'b1011;
    tick();
    check_value("t1_active", 32'(state), 32'd1);
    check_value("t1_error",  32'(Error), 32'd0);

    // 2: all FIFOs non-empty, egress ready for 5 cycles.
    fifo_empty   = 4'b0000;
    egress_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_value("t2_read",  32'(read),      32'(1 << exp_ch[c]));
      check_value("t2_popch", 32'(pop_ch),    32'(exp_ch[c]));
      check_value("t2_popv",  32'(pop_valid), 32'd1);
      tick();
    end
    egress_ready = 1'b0;

    // 3: pause hysteresis on channel 1.
    almost_full = 4'b0010;
    #1;
    check_value("t3_pre", 32'(fifo_pause), 32'b0000);
    tick();
    almost_full = 4'b0000;
    check_value("t3_set", 32'(fifo_pause), 32'b0010);
    repeat (3) tick();
    check_value("t3_hold", 32'(fifo_pause), 32'b0010);
    almost_empty = 4'b0010;
    #1;
    check_value("t3_hold2", 32'(fifo_pause), 32'b0010);
    tick();
    almost_empty = 4'b0000;
    check_value("t3_clr", 32'(fifo_pause), 32'b0000);

    // Both flags high: set wins. Fifo_full forces set over almost_empty.
    almost_full  = 4'b0001;
    almost_empty = 4'b0001;
    tick();
    check_value("t3_both", 32'(fifo_pause), 32'b0001);
    almost_full  = 4'b0000;
    almost_empty = 4'b0101;
    Fifo_full    = 4'b0100;
    tick();
    check_value("t3_full", 32'(fifo_pause), 32'b0100);
    Fifo_full    = 4'b0000;
    almost_empty = 4'b0100;
    tick();
    almost_empty = 4'b0000;
    check_value("t3_fclr", 32'(fifo_pause), 32'b0000);

    // ACTIVE holds while a write occurs with all FIFOs empty, then idles.
    fifo_empty = 4'b1111;
    push_0     = 1'b1;
    push_dest  = 2'd0;
    #1;
    check_value("fsm_write", 32'(write), 32'b0001);
    tick();
    check_value("fsm_hold", 32'(state), 32'd1);
    push_0 = 1'b0;
    tick();
    check_value("fsm_idle", 32'(state), 32'd0);
    fifo_empty = 4'b0000;
    tick();
    check_value("fsm_act", 32'(state), 32'd1);

    // 6: reset during a grant (rr_ptr is 1 after the five grants above).
    egress_ready = 1'b1;
    #1;
    check_value("t6_read", 32'(read),   32'b0010);
    check_value("t6_ch",   32'(pop_ch), 32'd1);
    reset = 1'b1;
    tick();
    check_value("t6_rread",  32'(read),      32'b0000);
    check_value("t6_rpopv",  32'(pop_valid), 32'd0);
    check_value("t6_rstate", 32'(state),     32'd0);
    reset = 1'b0;
    tick();
    check_value("t6_first",   32'(read),   32'b0001);
    check_value("t6_firstch", 32'(pop_ch), 32'd0);
    egress_ready = 1'b0;

    // 4: overflow on channel 3.
    push_0    = 1'b1;
    push_dest = 2'd3;
    Fifo_full = 4'b1000;
    #1;
    check_value("t4_write", 32'(write), 32'b0000);
    tick();
    push_0       = 1'b0;
    Fifo_full    = 4'b0000;
    egress_ready = 1'b1;
    #1;
    check_value("t4_error", 32'(Error),      32'd1);
    check_value("t4_state", 32'(state),      32'd2);
    check_value("t4_pause", 32'(fifo_pause), 32'b1111);
    check_value("t4_read",  32'(read),       32'b0000);
    check_value("t4_popv",  32'(pop_valid),  32'd0);
    check_value("t4_cnt",   32'(err_count),  32'(EXP_CNT_ONE));
    push_0    = 1'b1;
    push_dest = 2'd1;
    #1;
    check_value("t4_wblk", 32'(write), 32'b0000);
    push_0 = 1'b0;

    // 5: sustained FIFO error saturates the counter, then reset clears all.
    fifo_error = 4'b0001;
    repeat (300) tick();
    fifo_error = 4'b0000;
    check_value("t5_sat",   32'(err_count), 32'(EXP_CNT_SAT));
    check_value("t5_state", 32'(state),     32'd2);
    egress_ready = 1'b0;
    fifo_empty   = 4'b1111;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t5_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
